// File: rtl/servo_sequencer.sv
// Four-joint servo position sequencer: accepts per-joint targets and slews each
// joint toward its target in bounded steps once per servo frame.
module servo_sequencer #(
  parameter int STEP_TICKS = 1_000_000,
  parameter int STEP_SIZE  = 5,
  parameter int HOME_POS   = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        halt,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_joint,
  input  logic [6:0]  cmd_pos,
  output logic        cmd_err,
  output logic [3:0]  pwm_en,
  output logic [27:0] pos_bus,
  output logic        busy,
  output logic        done,
  output logic [1:0]  state_dbg
);

  localparam int CW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_TICKS - 1);
  localparam logic signed [7:0] SS = 8'(STEP_SIZE);

  typedef enum logic [1:0] {
    S_DISABLED = 2'd0,
    S_IDLE     = 2'd1,
    S_MOVING   = 2'd2,
    S_HALTED   = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [6:0]    pos [4];
  logic [6:0]    tgt [4];
  logic [6:0]    pos_nx [4];
  logic [6:0]    tgt_nx [4];
  logic [CW-1:0] cnt, cnt_nx;
  logic          accept, legal, tick, done_nx, all_eq;

  // One step toward t, never past it; the difference is taken as 8-bit signed.
  function automatic logic [6:0] step_to(input logic [6:0] p, input logic [6:0] t);
    logic signed [7:0] d;
    d = $signed({1'b0, t}) - $signed({1'b0, p});
    if (d > SS)       return p + 7'(STEP_SIZE);
    else if (d < -SS) return p - 7'(STEP_SIZE);
    else              return t;
  endfunction

  // Handshake: a command transfers on any edge where cmd_valid && cmd_ready;
  // cmd_ready is registered and high only in IDLE and MOVING, and valid never waits on ready.
  always_comb begin
    accept   = cmd_valid && cmd_ready;
    legal    = (cmd_pos <= 7'd100);
    tick     = (state == S_MOVING) && (cnt == LAST);
    state_nx = state;
    cnt_nx   = '0;
    done_nx  = 1'b0;
    all_eq   = 1'b1;
    for (int j = 0; j < 4; j++) begin
      pos_nx[j] = pos[j];
      tgt_nx[j] = (accept && legal && cmd_joint == 2'(j)) ? cmd_pos : tgt[j];
    end
    if (!enable) begin
      state_nx = S_DISABLED;
      for (int j = 0; j < 4; j++) tgt_nx[j] = pos[j];
    end else begin
      case (state)
        S_DISABLED: state_nx = S_IDLE;
        S_IDLE: begin
          if (halt) begin
            state_nx = S_HALTED;
            for (int j = 0; j < 4; j++) tgt_nx[j] = pos[j];
          end else if (accept && legal && cmd_pos != pos[cmd_joint]) begin
            state_nx = S_MOVING;
          end
        end
        S_MOVING: begin
          if (halt) begin
            state_nx = S_HALTED;
            for (int j = 0; j < 4; j++) tgt_nx[j] = pos[j];
          end else begin
            cnt_nx = tick ? '0 : cnt + CW'(1);
            if (tick) begin
              // A joint being retargeted on this tick sits the step out.
              for (int j = 0; j < 4; j++) begin
                if (!(accept && cmd_joint == 2'(j))) pos_nx[j] = step_to(pos[j], tgt[j]);
                if (pos_nx[j] != tgt_nx[j]) all_eq = 1'b0;
              end
              if (all_eq) begin
                state_nx = S_IDLE;
                done_nx  = 1'b1;
              end
            end
          end
        end
        S_HALTED: if (!halt) state_nx = S_IDLE;
        default:  state_nx = S_DISABLED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_DISABLED;
      cnt       <= '0;
      for (int j = 0; j < 4; j++) begin
        pos[j] <= 7'(HOME_POS);
        tgt[j] <= 7'(HOME_POS);
      end
      pwm_en    <= 4'h0;
      cmd_ready <= 1'b0;
      cmd_err   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pos       <= pos_nx;
      tgt       <= tgt_nx;
      pwm_en    <= (state_nx == S_DISABLED) ? 4'h0 : 4'hF;
      cmd_ready <= (state_nx == S_IDLE) || (state_nx == S_MOVING);
      cmd_err   <= accept && !legal;
      busy      <= (state_nx == S_MOVING);
      done      <= done_nx;
    end
  end

  assign pos_bus   = {pos[3], pos[2], pos[1], pos[0]};
  assign state_dbg = state;

endmodule

// File: tb/tb_servo_sequencer.sv
// Directed bench for servo_sequencer with STEP_TICKS=4: expected position
// snapshots are queued when a command is issued and checked as each step lands.
module tb_servo_sequencer;

  logic        clk = 1'b0;
  logic        rst, enable, halt, cmd_valid;
  logic        cmd_ready, cmd_err, busy, done;
  logic [1:0]  cmd_joint, state_dbg;
  logic [6:0]  cmd_pos;
  logic [3:0]  pwm_en;
  logic [27:0] pos_bus;

  logic [27:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;
  int done_cnt = 0;

  localparam logic [1:0] ST_DIS = 2'd0, ST_IDLE = 2'd1, ST_MOV = 2'd2, ST_HALT = 2'd3;

  servo_sequencer #(.STEP_TICKS(4), .STEP_SIZE(5), .HOME_POS(50)) dut (
    .clk(clk), .rst(rst), .enable(enable), .halt(halt),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_joint(cmd_joint),
    .cmd_pos(cmd_pos), .cmd_err(cmd_err), .pwm_en(pwm_en), .pos_bus(pos_bus),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  function automatic logic [27:0] pk(input int a, input int b, input int c, input int d);
    return {7'(d), 7'(c), 7'(b), 7'(a)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // driver tasks
  task automatic send_cmd(input logic [1:0] j, input logic [6:0] p);
    cmd_valid = 1'b1;
    cmd_joint = j;
    cmd_pos   = p;
    cyc(1);
    cmd_valid = 1'b0;
  endtask

  // Waits for the next position change, then pops and compares the expected snapshot.
  task automatic wait_step(input string tag, input logic exp_done);
    logic [27:0] prev, exp;
    int n;
    prev = pos_bus;
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (pos_bus == prev && n < 12);
    check({tag, "_gap"}, n, 4);
    if (exp_q.size() == 0) begin
      check({tag, "_qempty"}, 1, 0);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_pos"}, pos_bus, exp);
    end
    check({tag, "_done"}, done, exp_done);
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; halt = 1'b0;
    cmd_valid = 1'b0; cmd_joint = 2'd0; cmd_pos = 7'd0;
    cyc(2);
    check("rst_state", state_dbg, ST_DIS);
    check("rst_pwm", pwm_en, 4'h0);
    check("rst_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", cmd_err, 0);
    check("rst_pos", pos_bus, pk(50, 50, 50, 50));

    rst = 1'b1;
    cyc(1);
    check("dis_hold", state_dbg, ST_DIS);
    enable = 1'b1;
    cyc(1);
    check("en_state", state_dbg, ST_IDLE);
    check("en_pwm", pwm_en, 4'hF);
    check("en_ready", cmd_ready, 1);
    check("en_pos", pos_bus, pk(50, 50, 50, 50));

    // joint0 -> 62
    send_cmd(2'd0, 7'd62);
    check("mv_busy", busy, 1);
    exp_q.push_back(pk(55, 50, 50, 50));
    exp_q.push_back(pk(60, 50, 50, 50));
    exp_q.push_back(pk(62, 50, 50, 50));
    wait_step("mv1", 0);
    wait_step("mv2", 0);
    wait_step("mv3", 1);
    cyc(1);
    check("mv_done_off", done, 0);
    check("mv_busy_off", busy, 0);
    check("mv_idle", state_dbg, ST_IDLE);
    check("mv_done_cnt", done_cnt, 1);

    // illegal position
    send_cmd(2'd2, 7'd101);
    check("ill_err", cmd_err, 1);
    check("ill_state", state_dbg, ST_IDLE);
    cyc(1);
    check("ill_err_off", cmd_err, 0);
    cyc(6);
    check("ill_pos", pos_bus, pk(62, 50, 50, 50));
    check("ill_idle", state_dbg, ST_IDLE);
    check("ill_done_cnt", done_cnt, 1);

    // halt after first step
    send_cmd(2'd1, 7'd80);
    exp_q.push_back(pk(62, 55, 50, 50));
    wait_step("h1", 0);
    halt = 1'b1;
    cyc(1);
    check("h_state", state_dbg, ST_HALT);
    check("h_ready", cmd_ready, 0);
    check("h_busy", busy, 0);
    check("h_pwm", pwm_en, 4'hF);
    cyc(8);
    check("h_frozen", pos_bus, pk(62, 55, 50, 50));
    halt = 1'b0;
    cyc(1);
    check("h_rel_state", state_dbg, ST_IDLE);
    cyc(8);
    check("h_rel_pos", pos_bus, pk(62, 55, 50, 50));
    check("h_rel_idle", state_dbg, ST_IDLE);
    check("h_done_cnt", done_cnt, 1);

    // disable mid-move
    send_cmd(2'd1, 7'd70);
    exp_q.push_back(pk(62, 60, 50, 50));
    wait_step("d1", 0);
    cyc(1);
    enable = 1'b0;
    cyc(1);
    check("d_state", state_dbg, ST_DIS);
    check("d_pwm", pwm_en, 4'h0);
    check("d_ready", cmd_ready, 0);
    cyc(5);
    check("d_pos", pos_bus, pk(62, 60, 50, 50));
    enable = 1'b1;
    cyc(1);
    check("re_state", state_dbg, ST_IDLE);
    check("re_pwm", pwm_en, 4'hF);
    cyc(6);
    check("re_pos", pos_bus, pk(62, 60, 50, 50));
    check("re_idle", state_dbg, ST_IDLE);

    // command on the tick cycle, then reset mid-move
    send_cmd(2'd0, 7'd40);
    cyc(3);
    cmd_valid = 1'b1; cmd_joint = 2'd3; cmd_pos = 7'd70;
    cyc(1);
    cmd_valid = 1'b0;
    check("tk_pos", pos_bus, pk(57, 60, 50, 50));
    check("tk_busy", busy, 1);
    exp_q.push_back(pk(52, 60, 50, 55));
    wait_step("tk2", 0);
    cyc(2);
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    check("mr_pos", pos_bus, pk(50, 50, 50, 50));
    check("mr_state", state_dbg, ST_DIS);
    check("mr_busy", busy, 0);
    check("mr_pwm", pwm_en, 4'h0);
    check("mr_done", done, 0);
    cyc(3);
    check("end_done_cnt", done_cnt, 1);
    check("end_q", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/servo_sequencer.md
SERVO_SEQUENCER -- requirements
Module: servo_sequencer

Interface
REQ-001 Parameter STEP_TICKS, default 1_000_000, clk cycles between position steps (one 20 ms servo frame).
REQ-002 Parameter STEP_SIZE, default 5, maximum position change per joint per step, in percent.
REQ-003 Parameter HOME_POS, default 50, reset position of every joint, in percent.
REQ-004 Port clk  in  1  single system clock; all logic on posedge clk.
REQ-005 Port rst  in  1  synchronous active-low reset.
REQ-006 Port enable  in  1  arm power enable; level-sensitive.
REQ-007 Port halt  in  1  motion freeze; level-sensitive.
REQ-008 Port cmd_valid  in  1  command request.
REQ-009 Port cmd_ready  out  1  command accept.
REQ-010 Port cmd_joint  in  2  target joint index 0..3.
REQ-011 Port cmd_pos  in  7  target position, unsigned percent; legal range 0..100.
REQ-012 Port cmd_err  out  1  one-cycle pulse on an illegal accepted command.
REQ-013 Port pwm_en  out  4  per-joint enable to the PWM channels.
REQ-014 Port pos_bus  out  28  current positions, joint j at bits [7j+6:7j].
REQ-015 Port busy  out  1  high while in state MOVING.
REQ-016 Port done  out  1  one-cycle pulse on move completion.

Function
REQ-017 FSM SHALL have four states, DISABLED, IDLE, MOVING and HALTED, with all outputs registered.
REQ-018 A command SHALL be accepted only on a cycle where cmd_valid and cmd_ready are both 1; cmd_ready=1 only in IDLE and MOVING.
REQ-019 An accepted command with cmd_pos<=100 SHALL write target[cmd_joint] on the same edge.
REQ-020 An accepted command with cmd_pos>100 SHALL leave all targets unchanged and pulse cmd_err for one cycle.
REQ-021 Every transition out of DISABLED requires enable=1; DISABLED -> IDLE next cycle, and pwm_en=4'hF from that cycle onward.
REQ-022 In IDLE, an accepted legal command with target != pos SHALL move the FSM to MOVING and clear the tick counter to 0; target == pos SHALL stay in IDLE with no done pulse.
REQ-023 In MOVING, tick counter SHALL count 0..STEP_TICKS-1 and wrap; a tick occurs on the cycle the counter equals STEP_TICKS-1; retargeting SHALL NOT reset the counter.
REQ-024 On a tick, each joint with pos != target SHALL step toward the target by min(STEP_SIZE, |target-pos|), with no overshoot.
REQ-025 Position arithmetic SHALL use 8-bit signed differences, and pos SHALL stay within 0..100 with no wrap.
REQ-026 If a command for joint j is accepted on the same cycle as a tick, the step for joint j SHALL be skipped that tick; other joints step normally.
REQ-027 On a tick after which all four pos equal their targets, FSM SHALL enter IDLE and done SHALL pulse for exactly that one cycle.
REQ-028 halt=1 in IDLE or MOVING SHALL enter HALTED next cycle, set every target to the current pos, and clear the tick counter; pwm_en stays 4'hF.
REQ-029 In HALTED, cmd_ready=0 and positions are frozen; halt=0 SHALL return the FSM to IDLE with no done pulse.
REQ-030 enable=0 SHALL enter DISABLED next cycle from any state, with priority over halt and commands.
REQ-031 On entry to DISABLED, pwm_en=0, every target SHALL be set to the current pos, and positions are retained.
REQ-032 The tick counter SHALL be held at 0 in every state except MOVING.

Reset
REQ-033 rst=0 at a clk edge SHALL force state DISABLED, every pos and target to HOME_POS, tick counter 0, pwm_en=0, cmd_ready=0, cmd_err=0, busy=0, done=0, and pos_bus=4x50.
REQ-034 Reset asserted mid-move SHALL abandon the move with no done pulse, and takes priority over all inputs.

Verification (STEP_TICKS=4, STEP_SIZE=5, HOME_POS=50)
REQ-035 Release reset, then enable=1 -> next cycle pwm_en=4'hF, cmd_ready=1, and pos_bus holds 50 on all joints.
REQ-036 Command joint0=62 -> busy=1; joint0 reads 55, then 60, then 62 on ticks 4 cycles apart; done pulses once on the tick that reaches 62; busy=0 the following cycle.
REQ-037 Command joint2=101 -> cmd_err pulses for 1 cycle; target stays 50; FSM stays IDLE; no done.
REQ-038 Command joint1=80, then halt=1 after the first tick (pos 55) -> HALTED, pos frozen at 55, cmd_ready=0; release halt -> IDLE, no done.
REQ-039 enable=0 during MOVING -> DISABLED next cycle, pwm_en=0; re-enable -> IDLE with positions unchanged.
REQ-040 Command joint3=70 accepted on the same cycle as a tick -> joint3 unchanged on that tick and 55 on the next tick; rst=0 mid-move -> all joints 50 and state DISABLED.
